// File: rtl/forward_maccum_folded_pkg.sv
// Shared parameters for the folded forward multiply-accumulate element:
// mode encodings, FSM state type and width helpers.
package forward_maccum_folded_pkg;

  localparam logic MODE_TEST  = 1'b0;
  localparam logic MODE_TRAIN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Accumulator width: enough headroom for NP products of WF-bit words.
  function automatic int wa_width(input int np, input int wf);
    return $clog2(np) + 1 + wf;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/forward_maccum_folded_if.sv
// Handshake and data bundle between the weight/state sources, the
// folded MAC element and its two result consumers.
interface forward_maccum_folded_if
  import forward_maccum_folded_pkg::*;
#(
  parameter int NP = 7,
  parameter int NC = 11,
  parameter int WF = 5
) ();
  localparam int WA = wa_width(NP, WF);

  logic                      iValid_AM_WeightBias;
  logic                      oReady_AM_WeightBias;
  logic [NC*NP*WF+NC*WF-1:0] iData_AM_WeightBias;
  logic                      iValid_AM_State0;
  logic                      oReady_AM_State0;
  logic [NP*WF-1:0]          iData_AM_State0;
  logic                      oValid_BM_Accum0;
  logic                      iReady_BM_Accum0;
  logic [NC*WA-1:0]          oData_BM_Accum0;
  logic                      oValid_BM_Accum1;
  logic                      iReady_BM_Accum1;
  logic [NC*WA-1:0]          oData_BM_Accum1;

  modport slave (
    input  iValid_AM_WeightBias, iData_AM_WeightBias,
    input  iValid_AM_State0, iData_AM_State0,
    input  iReady_BM_Accum0, iReady_BM_Accum1,
    output oReady_AM_WeightBias, oReady_AM_State0,
    output oValid_BM_Accum0, oData_BM_Accum0,
    output oValid_BM_Accum1, oData_BM_Accum1
  );

  modport master (
    output iValid_AM_WeightBias, iData_AM_WeightBias,
    output iValid_AM_State0, iData_AM_State0,
    output iReady_BM_Accum0, iReady_BM_Accum1,
    input  oReady_AM_WeightBias, oReady_AM_State0,
    input  oValid_BM_Accum0, oData_BM_Accum0,
    input  oValid_BM_Accum1, oData_BM_Accum1
  );

endinterface

// File: rtl/forward_maccum_lane.sv
// One MAC lane: signed WF x WF multiply, arithmetic shift by FRAC, and a
// wrapping WA-bit accumulator that reloads from the sign-extended bias.
module forward_maccum_lane
  import forward_maccum_folded_pkg::*;
#(
  parameter int WF   = 5,
  parameter int FRAC = 2,
  parameter int WA   = wa_width(7, 5)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load,
  input  logic [WF-1:0] w,
  input  logic [WF-1:0] s,
  input  logic [WF-1:0] bias,
  output logic [WA-1:0] sum
);
  // Work width covers the full product and the accumulator alike.
  localparam int MW = (2 * WF > WA) ? 2 * WF : WA;

  logic signed [MW-1:0] w_ext;
  logic signed [MW-1:0] s_ext;
  logic signed [MW-1:0] prod;
  logic [WA-1:0]        term;
  logic [WA-1:0]        base;
  logic [WA-1:0]        acc;

  assign w_ext = MW'($signed(w));
  assign s_ext = MW'($signed(s));
  assign prod  = w_ext * s_ext;
  assign term  = WA'(prod >>> FRAC);
  assign base  = load ? WA'($signed(bias)) : acc;
  assign sum   = base + term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/forward_maccum_folded.sv
// Time-folded forward MAC layer: NC neurons of NP inputs computed on LANES
// lanes over G = NC/LANES groups, with dual result ports (TRAIN copy).
//   state | meaning
//   IDLE  | waiting for joint weight/bias + state accept
//   RUN   | one (g,p) step per edge across all lanes
//   OUT   | results held until both ports are done
module forward_maccum_folded
  import forward_maccum_folded_pkg::*;
#(
  parameter int NP    = 7,
  parameter int NC    = 11,
  parameter int WF    = 5,
  parameter int FRAC  = 2,
  parameter int LANES = 1
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iMode,
  forward_maccum_folded_if.slave bus
);
  localparam int WA  = wa_width(NP, WF);
  localparam int G   = NC / LANES;
  localparam int PW  = cnt_width(NP);
  localparam int GW  = cnt_width(G);
  localparam int WBW = NC * NP * WF + NC * WF;
  localparam logic [PW-1:0] P_LAST = PW'(NP - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  state_t           state;
  state_t           state_nx;
  logic [PW-1:0]    p;
  logic [GW-1:0]    g;
  logic [WBW-1:0]   wb_q;
  logic [NP*WF-1:0] st_q;
  logic             mode_q;
  logic [NC*WA-1:0] res_q;
  logic             done0;
  logic             done1;
  logic             accept;
  logic             run_last;
  logic             valid0;
  logic             valid1;
  logic             fire0;
  logic             fire1;
  logic             all_done;
  logic             lane_en;
  logic             lane_load;

  logic [WF-1:0] w_sel [LANES];
  logic [WF-1:0] b_sel [LANES];
  logic [WF-1:0] s_sel;
  logic [WA-1:0] lane_sum [LANES];

  assign run_last  = (state == ST_RUN) && (p == P_LAST) && (g == G_LAST);
  assign lane_en   = (state == ST_RUN);
  assign lane_load = (p == '0);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    valid0   = 1'b0;
    valid1   = 1'b0;
    fire0    = 1'b0;
    fire1    = 1'b0;
    all_done = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = bus.iValid_AM_WeightBias & bus.iValid_AM_State0;
        if (accept) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (run_last) state_nx = ST_OUT;
      end
      ST_OUT: begin
        valid0   = !done0;
        valid1   = (mode_q == MODE_TRAIN) && !done1;
        fire0    = valid0 & bus.iReady_BM_Accum0;
        fire1    = valid1 & bus.iReady_BM_Accum1;
        // In TEST the training copy never goes valid and counts as done.
        all_done = (done0 | fire0) & (done1 | fire1 | (mode_q == MODE_TEST));
        if (all_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    s_sel = st_q[int'(p)*WF +: WF];
    for (int l = 0; l < LANES; l++) begin
      w_sel[l] = wb_q[((int'(g)*LANES + l)*NP + int'(p))*WF +: WF];
      b_sel[l] = wb_q[NC*NP*WF + (int'(g)*LANES + l)*WF +: WF];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    forward_maccum_lane #(
      .WF   (WF),
      .FRAC (FRAC),
      .WA   (WA)
    ) u_lane (
      .clk   (iCLK),
      .rst_n (iRST),
      .en    (lane_en),
      .load  (lane_load),
      .w     (w_sel[l]),
      .s     (s_sel),
      .bias  (b_sel[l]),
      .sum   (lane_sum[l])
    );
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      p      <= '0;
      g      <= '0;
      wb_q   <= '0;
      st_q   <= '0;
      mode_q <= MODE_TEST;
      res_q  <= '0;
      done0  <= 1'b0;
      done1  <= 1'b0;
    end else begin
      if (accept) begin
        wb_q   <= bus.iData_AM_WeightBias;
        st_q   <= bus.iData_AM_State0;
        mode_q <= iMode;
        p      <= '0;
        g      <= '0;
        done0  <= 1'b0;
        done1  <= 1'b0;
      end
      if (state == ST_RUN) begin
        if (p == P_LAST) begin
          p <= '0;
          g <= (g == G_LAST) ? '0 : g + 1'b1;
          for (int l = 0; l < LANES; l++) begin
            res_q[(int'(g)*LANES + l)*WA +: WA] <= lane_sum[l];
          end
        end else begin
          p <= p + 1'b1;
        end
      end
      if (fire0) done0 <= 1'b1;
      if (fire1) done1 <= 1'b1;
    end
  end

  // Ready is forced low while reset is held, even though IDLE is the reset state.
  assign bus.oReady_AM_WeightBias = iRST & (state == ST_IDLE) & bus.iValid_AM_State0;
  assign bus.oReady_AM_State0     = iRST & (state == ST_IDLE) & bus.iValid_AM_WeightBias;
  assign bus.oValid_BM_Accum0     = valid0;
  assign bus.oValid_BM_Accum1     = valid1;
  assign bus.oData_BM_Accum0      = res_q;
  assign bus.oData_BM_Accum1      = res_q;

endmodule

// File: tb/tb_forward_maccum_folded.sv
// Directed bench: a 2x2 single-lane instance and a 2x4 two-lane instance,
// hand-computed Q4 results, handshake ordering, join rule and reset.
module tb_forward_maccum_folded;
  import forward_maccum_folded_pkg::*;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic mode_a = 1'b0;
  logic mode_b = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  localparam logic [47:0] WB_V1 = {8'h08, 8'h00, 32'h10101010};
  localparam logic [15:0] ST_V1 = {8'h10, 8'h20};
  localparam logic [19:0] RES_V1 = {10'h038, 10'h030};
  localparam logic [47:0] WB_V2 = {8'hFC, 8'h04, 32'hE02010F0};
  localparam logic [15:0] ST_V2 = {8'h08, 8'h30};
  localparam logic [19:0] RES_V2 = {10'h04C, 10'h3DC};
  localparam logic [95:0] WB_B  = {8'hFF, 8'h03, 8'h02, 8'h01, 64'h10107F7F7F7F7F7F};
  localparam logic [15:0] ST_B  = {8'h7F, 8'h7F};
  localparam logic [39:0] RES_B = {10'h0FD, 10'h3E3, 10'h3E2, 10'h3E1};

  always #5 clk = ~clk;

  forward_maccum_folded_if #(.NP(2), .NC(2), .WF(8)) bus_a ();
  forward_maccum_folded_if #(.NP(2), .NC(4), .WF(8)) bus_b ();

  forward_maccum_folded #(.NP(2), .NC(2), .WF(8), .FRAC(4), .LANES(1)) dut_a (
    .iCLK (clk), .iRST (rst_n), .iMode (mode_a), .bus (bus_a.slave)
  );
  forward_maccum_folded #(.NP(2), .NC(4), .WF(8), .FRAC(4), .LANES(2)) dut_b (
    .iCLK (clk), .iRST (rst_n), .iMode (mode_b), .bus (bus_b.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out_a(output int n);
    n = 0;
    while (bus_a.oValid_BM_Accum0 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_out_b(output int n);
    n = 0;
    while (bus_b.oValid_BM_Accum0 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called on a negedge in IDLE; returns on the negedge after the accept edge.
  task automatic accept_a(input logic [47:0] wb, input logic [15:0] st, input logic m);
    bus_a.iData_AM_WeightBias  = wb;
    bus_a.iData_AM_State0      = st;
    mode_a                     = m;
    bus_a.iValid_AM_WeightBias = 1'b1;
    bus_a.iValid_AM_State0     = 1'b1;
    @(negedge clk);
    bus_a.iValid_AM_WeightBias = 1'b0;
    bus_a.iValid_AM_State0     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.iValid_AM_WeightBias = 1'b1;
    bus_a.iData_AM_WeightBias  = '0;
    bus_a.iValid_AM_State0     = 1'b1;
    bus_a.iData_AM_State0      = '0;
    bus_a.iReady_BM_Accum0     = 1'b0;
    bus_a.iReady_BM_Accum1     = 1'b0;
    bus_b.iValid_AM_WeightBias = 1'b0;
    bus_b.iData_AM_WeightBias  = '0;
    bus_b.iValid_AM_State0     = 1'b0;
    bus_b.iData_AM_State0      = '0;
    bus_b.iReady_BM_Accum0     = 1'b0;
    bus_b.iReady_BM_Accum1     = 1'b0;

    // Reset values with both input valids asserted
    repeat (2) @(negedge clk);
    check("rst_ready_wb", bus_a.oReady_AM_WeightBias, 1'b0);
    check("rst_ready_st", bus_a.oReady_AM_State0, 1'b0);
    check("rst_valid0", bus_a.oValid_BM_Accum0, 1'b0);
    check("rst_valid1", bus_a.oValid_BM_Accum1, 1'b0);
    check("rst_data0", bus_a.oData_BM_Accum0, 20'h0);
    bus_a.iValid_AM_WeightBias = 1'b0;
    bus_a.iValid_AM_State0     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Join: only the state valid for 5 cycles, then weights arrive
    bus_a.iData_AM_WeightBias = WB_V1;
    bus_a.iData_AM_State0     = ST_V1;
    mode_a                    = MODE_TRAIN;
    bus_a.iValid_AM_State0    = 1'b1;
    repeat (5) @(negedge clk);
    check("join_ready_st_alone", bus_a.oReady_AM_State0, 1'b0);
    check("join_ready_wb_idle", bus_a.oReady_AM_WeightBias, 1'b1);
    check("join_no_valid", bus_a.oValid_BM_Accum0, 1'b0);
    bus_a.iValid_AM_WeightBias = 1'b1;
    #1;
    check("join_ready_st", bus_a.oReady_AM_State0, 1'b1);
    @(negedge clk);
    check("run_ready_wb", bus_a.oReady_AM_WeightBias, 1'b0);
    bus_a.iValid_AM_WeightBias = 1'b0;
    bus_a.iValid_AM_State0     = 1'b0;
    wait_out_a(lat);
    check("train_latency", lat, 4);
    check("train_data0", bus_a.oData_BM_Accum0, RES_V1);
    check("train_data1", bus_a.oData_BM_Accum1, RES_V1);
    check("train_valid1", bus_a.oValid_BM_Accum1, 1'b1);

    // Accum0 accepted three cycles before Accum1
    bus_a.iReady_BM_Accum0 = 1'b1;
    @(negedge clk);
    bus_a.iReady_BM_Accum0 = 1'b0;
    bus_a.iValid_AM_State0 = 1'b1;
    check("split_valid0_drop", bus_a.oValid_BM_Accum0, 1'b0);
    check("split_valid1_hold", bus_a.oValid_BM_Accum1, 1'b1);
    check("split_not_idle", bus_a.oReady_AM_WeightBias, 1'b0);
    repeat (2) @(negedge clk);
    check("split_data_stable", bus_a.oData_BM_Accum0, RES_V1);
    check("split_still_out", bus_a.oReady_AM_WeightBias, 1'b0);
    bus_a.iReady_BM_Accum1 = 1'b1;
    @(negedge clk);
    bus_a.iReady_BM_Accum1 = 1'b0;
    check("split_valid1_drop", bus_a.oValid_BM_Accum1, 1'b0);
    check("split_idle", bus_a.oReady_AM_WeightBias, 1'b1);
    bus_a.iValid_AM_State0 = 1'b0;
    @(negedge clk);

    // TEST mode, mode toggled after accept, Accum1 never ready
    accept_a(WB_V2, ST_V2, MODE_TEST);
    mode_a = MODE_TRAIN;
    wait_out_a(lat);
    check("test_latency", lat, 4);
    check("test_data0", bus_a.oData_BM_Accum0, RES_V2);
    check("test_data1_mirror", bus_a.oData_BM_Accum1, RES_V2);
    check("test_valid1_low", bus_a.oValid_BM_Accum1, 1'b0);
    bus_a.iReady_BM_Accum0 = 1'b1;
    bus_a.iValid_AM_State0 = 1'b1;
    @(negedge clk);
    bus_a.iReady_BM_Accum0 = 1'b0;
    check("test_valid0_drop", bus_a.oValid_BM_Accum0, 1'b0);
    check("test_idle", bus_a.oReady_AM_WeightBias, 1'b1);
    bus_a.iValid_AM_State0 = 1'b0;
    @(negedge clk);

    // Reset mid-RUN with a mode toggle, then a clean TEST operation
    accept_a(WB_V1, ST_V1, MODE_TRAIN);
    @(negedge clk);
    rst_n  = 1'b0;
    mode_a = MODE_TEST;
    #1;
    check("midrst_valid0", bus_a.oValid_BM_Accum0, 1'b0);
    check("midrst_valid1", bus_a.oValid_BM_Accum1, 1'b0);
    check("midrst_data0", bus_a.oData_BM_Accum0, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept_a(WB_V1, ST_V1, MODE_TEST);
    wait_out_a(lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_data0", bus_a.oData_BM_Accum0, RES_V1);
    check("post_rst_valid1", bus_a.oValid_BM_Accum1, 1'b0);
    bus_a.iReady_BM_Accum0 = 1'b1;
    @(negedge clk);
    bus_a.iReady_BM_Accum0 = 1'b0;
    check("post_rst_done", bus_a.oValid_BM_Accum0, 1'b0);

    // Two lanes, wrapping accumulation, both outputs on the same edge
    bus_b.iData_AM_WeightBias  = WB_B;
    bus_b.iData_AM_State0      = ST_B;
    mode_b                     = MODE_TRAIN;
    bus_b.iValid_AM_WeightBias = 1'b1;
    bus_b.iValid_AM_State0     = 1'b1;
    @(negedge clk);
    bus_b.iValid_AM_WeightBias = 1'b0;
    bus_b.iValid_AM_State0     = 1'b0;
    wait_out_b(lat);
    check("lanes_latency", lat, 4);
    check("lanes_data0", bus_b.oData_BM_Accum0, RES_B);
    check("lanes_data1", bus_b.oData_BM_Accum1, RES_B);
    check("lanes_valid1", bus_b.oValid_BM_Accum1, 1'b1);
    bus_b.iReady_BM_Accum0 = 1'b1;
    bus_b.iReady_BM_Accum1 = 1'b1;
    bus_b.iValid_AM_State0 = 1'b1;
    @(negedge clk);
    bus_b.iReady_BM_Accum0 = 1'b0;
    bus_b.iReady_BM_Accum1 = 1'b0;
    check("lanes_valid0_drop", bus_b.oValid_BM_Accum0, 1'b0);
    check("lanes_valid1_drop", bus_b.oValid_BM_Accum1, 1'b0);
    check("lanes_idle", bus_b.oReady_AM_WeightBias, 1'b1);
    bus_b.iValid_AM_State0 = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
